// File: rtl/turn_sequencer.sv
// Turn/game-flow controller for the two-player artillery game: grants controls, pulses commands, keeps score.
// Optional turn timeout built only when TURN_SEQUENCER_TIMEOUT_EN is defined.
module turn_sequencer #(
   parameter int MOVE_BUDGET = 8,
   parameter int TURN_TICKS  = 200,
   parameter int WIN_SCORE   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_new_game,
   input  logic       btn_move_left,
   input  logic       btn_move_right,
   input  logic       btn_aim_left,
   input  logic       btn_aim_right,
   input  logic       btn_shoot,
   input  logic       shot_done,
   input  logic       shot_hit,
   output logic       move_left,
   output logic       move_right,
   output logic       aim_left,
   output logic       aim_right,
   output logic       shoot,
   output logic       player,
   output logic [3:0] moves_left,
   output logic [1:0] score0,
   output logic [1:0] score1,
   output logic [2:0] state,
   output logic       game_over,
   output logic       winner
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TURN   = 3'd1,
      FLIGHT = 3'd2,
      SWAP   = 3'd3,
      OVER   = 3'd4
   } state_t;

   localparam logic [3:0] BUDGET = 4'(MOVE_BUDGET);
   localparam logic [1:0] WIN    = 2'(WIN_SCORE);

   state_t     state_q, state_d;
   logic       player_q, player_d;
   logic [3:0] moves_q, moves_d;
   logic [1:0] score0_q, score0_d, score1_q, score1_d, new_score;
   logic       winner_q, winner_d, over_q, over_d;
   logic [4:0] cmd_q, cmd_d;          // {move_left, move_right, aim_left, aim_right, shoot}
   logic [4:0] btn, btn_prev, rise;
   logic       do_swap, expire;

   assign btn  = {btn_move_left, btn_move_right, btn_aim_left, btn_aim_right, btn_shoot};
   assign rise = btn & ~btn_prev;

`ifdef TURN_SEQUENCER_TIMEOUT_EN
   localparam logic [7:0] TICKS_INIT = 8'(TURN_TICKS);
   logic [7:0] timer_q;
   logic       reload;

   assign reload = do_swap | start_new_game;
   assign expire = (state_q == TURN) && tick && (timer_q == 8'd1);

   always_ff @(posedge clk) begin
      if (reset)
         timer_q <= '0;
      else if (reload)
         timer_q <= TICKS_INIT;
      else if (state_q == TURN && tick && timer_q != '0)
         timer_q <= timer_q - 8'd1;
   end
`else
   logic unused_timer_inputs;
   assign unused_timer_inputs = tick ^ (TURN_TICKS != 0);
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         player_q <= 1'b0;
         moves_q  <= '0;
         score0_q <= '0;
         score1_q <= '0;
         winner_q <= 1'b0;
         over_q   <= 1'b0;
         cmd_q    <= '0;
         btn_prev <= '0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         moves_q  <= moves_d;
         score0_q <= score0_d;
         score1_q <= score1_d;
         winner_q <= winner_d;
         over_q   <= over_d;
         cmd_q    <= cmd_d;
         btn_prev <= btn;
      end
   end

   always_comb begin
      state_d   = state_q;
      player_d  = player_q;
      moves_d   = moves_q;
      score0_d  = score0_q;
      score1_d  = score1_q;
      winner_d  = winner_q;
      cmd_d     = '0;
      do_swap   = 1'b0;
      new_score = (player_q ? score1_q : score0_q) + 2'd1;

      case (state_q)
         IDLE: ;
         TURN: begin
            // Any move edge blocks aim, even when cancelled or out of budget.
            if (rise[0]) begin
               cmd_d[0] = 1'b1;
               state_d  = FLIGHT;
            end else if (expire) begin
               do_swap = 1'b1;
            end else if (rise[4] | rise[3]) begin
               if ((rise[4] ^ rise[3]) && moves_q != '0) begin
                  cmd_d[4:3] = rise[4:3];
                  moves_d    = moves_q - 4'd1;
               end
            end else if (rise[2] ^ rise[1]) begin
               cmd_d[2:1] = rise[2:1];
            end
         end
         FLIGHT: begin
            if (shot_done) begin
               if (shot_hit) begin
                  if (player_q) score1_d = new_score;
                  else          score0_d = new_score;
               end
               if (shot_hit && new_score == WIN) begin
                  state_d  = OVER;
                  winner_d = player_q;
               end else begin
                  do_swap = 1'b1;
               end
            end
         end
         SWAP: state_d = TURN;
         OVER: ;
         default: state_d = IDLE;
      endcase

      // Player toggle and reload happen on entry to SWAP so the new player is visible during SWAP.
      if (do_swap) begin
         state_d  = SWAP;
         player_d = ~player_q;
         moves_d  = BUDGET;
      end

      if (start_new_game) begin
         state_d  = TURN;
         player_d = 1'b0;
         moves_d  = BUDGET;
         score0_d = '0;
         score1_d = '0;
         winner_d = 1'b0;
         cmd_d    = '0;
      end

      over_d = (state_d == OVER);
   end

   assign {move_left, move_right, aim_left, aim_right, shoot} = cmd_q;
   assign player     = player_q;
   assign moves_left = moves_q;
   assign score0     = score0_q;
   assign score1     = score1_q;
   assign state      = state_q;
   assign game_over  = over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Table-driven bench for turn_sequencer with a queue scoreboard of expected registered outputs.
module tb_turn_sequencer;

   logic clk = 1'b0;
   logic reset, tick, start_new_game, shot_done, shot_hit;
   logic btn_move_left, btn_move_right, btn_aim_left, btn_aim_right, btn_shoot;
   logic move_left, move_right, aim_left, aim_right, shoot, player, game_over, winner;
   logic [3:0] moves_left;
   logic [1:0] score0, score1;
   logic [2:0] state;

   always #5 clk = ~clk;

   turn_sequencer #(.MOVE_BUDGET(8), .TURN_TICKS(4), .WIN_SCORE(3)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start_new_game(start_new_game),
      .btn_move_left(btn_move_left), .btn_move_right(btn_move_right),
      .btn_aim_left(btn_aim_left), .btn_aim_right(btn_aim_right), .btn_shoot(btn_shoot),
      .shot_done(shot_done), .shot_hit(shot_hit),
      .move_left(move_left), .move_right(move_right), .aim_left(aim_left),
      .aim_right(aim_right), .shoot(shoot), .player(player), .moves_left(moves_left),
      .score0(score0), .score1(score1), .state(state), .game_over(game_over), .winner(winner)
   );

   typedef struct packed {
      logic [4:0] pulses;
      logic       pl;
      logic [3:0] moves;
      logic [1:0] s0;
      logic [1:0] s1;
      logic [2:0] st;
      logic       go;
      logic       win;
   } outs_t;

   typedef struct {
      logic [8:0] in;
      outs_t      exp;
   } vec_t;

   // Input bits: {start, move_l, move_r, aim_l, aim_r, shoot, done, hit, tick}
   localparam logic [8:0] ST = 9'h100, ML = 9'h080, MR = 9'h040, AL = 9'h020, AR = 9'h010;
   localparam logic [8:0] SH = 9'h008, DN = 9'h004, HT = 9'h002, TK = 9'h001, NO = 9'h000;
   localparam logic [4:0] P_ML = 5'h10, P_MR = 5'h08, P_AR = 5'h02, P_SH = 5'h01, P0 = 5'h00;
   localparam logic [2:0] S_I = 3'd0, S_T = 3'd1, S_F = 3'd2, S_S = 3'd3, S_O = 3'd4;

   outs_t act;
   assign act = {move_left, move_right, aim_left, aim_right, shoot, player, moves_left,
                 score0, score1, state, game_over, winner};

   vec_t  tbl[$];
   outs_t exp_q[$];
   int    n_vec = 0;
   int    n_fail = 0;

   function automatic outs_t o(logic [4:0] p, logic pl, int m, int a, int b, logic [2:0] st,
                               logic go = 1'b0, logic w = 1'b0);
      return {p, pl, 4'(m), 2'(a), 2'(b), st, go, w};
   endfunction

   function automatic void add(logic [8:0] in, outs_t e);
      vec_t v;
      v.in  = in;
      v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name);
      outs_t e;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         n_vec++;
         if (act !== e)
            begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", name, act, e);
            end
      end
   endtask

   task automatic step(input logic rst, input logic [8:0] in, input outs_t e, input string name);
      @(negedge clk);
      reset = rst;
      {start_new_game, btn_move_left, btn_move_right, btn_aim_left, btn_aim_right,
       btn_shoot, shot_done, shot_hit, tick} = in;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      {start_new_game, btn_move_left, btn_move_right, btn_aim_left, btn_aim_right,
       btn_shoot, shot_done, shot_hit, tick} = ML;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(o(P0, 0, 0, 0, 0, S_I));
      check("reset");

      // Held button's first post-reset edge lands in IDLE and is discarded.
      add(ML, o(P0, 0, 0, 0, 0, S_I));
      add(NO, o(P0, 0, 0, 0, 0, S_I));
      add(ST, o(P0, 0, 8, 0, 0, S_T));
      add(NO, o(P0, 0, 8, 0, 0, S_T));
      add(ML, o(P_ML, 0, 7, 0, 0, S_T));
      add(ML, o(P0, 0, 7, 0, 0, S_T));
      add(ML, o(P0, 0, 7, 0, 0, S_T));
      add(NO, o(P0, 0, 7, 0, 0, S_T));
      for (int i = 0; i < 7; i++) begin
         add(MR, o(P_MR, 0, 6 - i, 0, 0, S_T));
         add(NO, o(P0, 0, 6 - i, 0, 0, S_T));
      end
      add(ML, o(P0, 0, 0, 0, 0, S_T));
      add(NO, o(P0, 0, 0, 0, 0, S_T));
      add(AR, o(P_AR, 0, 0, 0, 0, S_T));
      add(NO, o(P0, 0, 0, 0, 0, S_T));
      add(AL | AR, o(P0, 0, 0, 0, 0, S_T));
      add(NO, o(P0, 0, 0, 0, 0, S_T));
      add(SH | MR, o(P_SH, 0, 0, 0, 0, S_F));
      add(NO, o(P0, 0, 0, 0, 0, S_F));
      add(ML, o(P0, 0, 0, 0, 0, S_F));
      add(NO, o(P0, 0, 0, 0, 0, S_F));
      add(DN, o(P0, 1, 8, 0, 0, S_S));
      add(NO, o(P0, 1, 8, 0, 0, S_T));
      add(DN | HT, o(P0, 1, 8, 0, 0, S_T));
      add(NO, o(P0, 1, 8, 0, 0, S_T));
      add(SH, o(P_SH, 1, 8, 0, 0, S_F));
      add(DN, o(P0, 0, 8, 0, 0, S_S));
      add(NO, o(P0, 0, 8, 0, 0, S_T));
      for (int r = 1; r <= 3; r++) begin
         add(SH, o(P_SH, 0, 8, r - 1, 0, S_F));
         if (r < 3) begin
            add(DN | HT, o(P0, 1, 8, r, 0, S_S));
            add(NO, o(P0, 1, 8, r, 0, S_T));
            add(SH, o(P_SH, 1, 8, r, 0, S_F));
            add(DN, o(P0, 0, 8, r, 0, S_S));
            add(NO, o(P0, 0, 8, r, 0, S_T));
         end else begin
            add(DN | HT, o(P0, 0, 8, 3, 0, S_O, 1, 0));
         end
      end
      add(ML, o(P0, 0, 8, 3, 0, S_O, 1, 0));
      add(NO, o(P0, 0, 8, 3, 0, S_O, 1, 0));
      add(SH, o(P0, 0, 8, 3, 0, S_O, 1, 0));
      add(DN | HT, o(P0, 0, 8, 3, 0, S_O, 1, 0));
      add(NO, o(P0, 0, 8, 3, 0, S_O, 1, 0));
      add(ST, o(P0, 0, 8, 0, 0, S_T));
      add(NO, o(P0, 0, 8, 0, 0, S_T));
      add(SH, o(P_SH, 0, 8, 0, 0, S_F));
      add(DN | HT, o(P0, 1, 8, 1, 0, S_S));
      add(NO, o(P0, 1, 8, 1, 0, S_T));
      add(SH, o(P_SH, 1, 8, 1, 0, S_F));

      foreach (tbl[i])
         step(1'b0, tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

      // Reset mid-flight with shot_done and a button edge in the same cycle.
      step(1'b1, DN | HT | MR, o(P0, 0, 0, 0, 0, S_I), "reset_in_flight");
      step(1'b0, NO, o(P0, 0, 0, 0, 0, S_I), "idle_after_reset");
      step(1'b0, ST, o(P0, 0, 8, 0, 0, S_T), "restart_for_timer");
`ifdef TURN_SEQUENCER_TIMEOUT_EN
      for (int i = 0; i < 3; i++)
         step(1'b0, TK, o(P0, 0, 8, 0, 0, S_T), $sformatf("tick%0d", i));
      step(1'b0, TK, o(P0, 1, 8, 0, 0, S_S), "timeout_swap");
      step(1'b0, NO, o(P0, 1, 8, 0, 0, S_T), "timeout_turn");
`else
      for (int i = 0; i < 300; i++)
         step(1'b0, TK, o(P0, 0, 8, 0, 0, S_T), $sformatf("tick%0d", i));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
